seven_seg_readback: RTL and testbench

//   Reader end of the multiplexed 7-segment display bus. Snoops active-low anode enables and

---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/seg_pattern_decoder.sv | 30 +++
 rtl/seven_seg_readback.sv | 212 +++++++++++++++++++++
 tb/tb_seven_seg_readback.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment patterns, digit codes and readback FSM states.
// Patterns are active-low {g,f,e,d,c,b,a}; 0 means the segment is lit.
package seven_seg_pkg;

    localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
    localparam logic [6:0] SEG_PAT_1 = 7'b1111001;
    localparam logic [6:0] SEG_PAT_2 = 7'b0100100;
    localparam logic [6:0] SEG_PAT_3 = 7'b0110000;
    localparam logic [6:0] SEG_PAT_4 = 7'b0011001;
    localparam logic [6:0] SEG_PAT_5 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_6 = 7'b0000010;
    localparam logic [6:0] SEG_PAT_7 = 7'b1111000;
    localparam logic [6:0] SEG_PAT_8 = 7'b0000000;
    localparam logic [6:0] SEG_PAT_9 = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_BLANK   = 4'hE;
    localparam logic [3:0] CODE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURED
    } rb_state_e;

endpackage

// File: rtl/seg_pattern_decoder.sv
// Inverse of the display encoder: 7-bit active-low pattern -> digit code.
// Latency: combinational. Backpressure: none.
module seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code = CODE_INVALID;
        case (seg_n)
            SEG_PAT_0: code = 4'h0;
            SEG_PAT_1: code = 4'h1;
            SEG_PAT_2: code = 4'h2;
            SEG_PAT_3: code = 4'h3;
            SEG_PAT_4: code = 4'h4;
            SEG_PAT_5: code = 4'h5;
            SEG_PAT_6: code = 4'h6;
            SEG_PAT_7: code = 4'h7;
            SEG_PAT_8: code = 4'h8;
            SEG_PAT_9: code = 4'h9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
        invalid = (code == CODE_INVALID);
    end

endmodule

// File: rtl/seven_seg_readback.sv
// Recovers the digits shown on a multiplexed 7-seg bus; SEVEN_SEG_READBACK_DP_EN adds dp_n/dp.
// Latency: 2 sync + STABLE_CYCLES per capture, frame one cycle after all positions seen.
// Backpressure: none, passive observer with single-cycle frame_valid/bad_pattern pulses.
module seven_seg_readback
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    input  logic [6:0]              seg_n,
`ifdef SEVEN_SEG_READBACK_DP_EN
    input  logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dp,
`endif
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    frame_valid,
    output logic                    bad_pattern,
    output logic                    stale
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef SEVEN_SEG_READBACK_DP_EN
    localparam int PAT_W = 8;
`else
    localparam int PAT_W = 7;
`endif

    logic [PAT_W-1:0]        pat_in;
    logic [NUM_DIGITS-1:0]   an_meta_q, an_sync_q;
    logic [PAT_W-1:0]        pat_meta_q, pat_sync_q;

    rb_state_e               state_q, state_d;
    logic [IDX_W-1:0]        lat_idx_q, lat_idx_d;
    logic [PAT_W-1:0]        lat_pat_q, lat_pat_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    bad_q, bad_d;
    logic                    stale_q, stale_d;
`ifdef SEVEN_SEG_READBACK_DP_EN
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, dp_q, dp_d;
    assign pat_in = {dp_n, seg_n};
    assign dp     = dp_q;
`else
    assign pat_in = seg_n;
`endif

    logic [NUM_DIGITS-1:0] an_low;
    logic                  an_single, same_sel, capture;
    logic [IDX_W-1:0]      an_idx;
    logic [3:0]            dec_code;
    logic                  dec_invalid;

    seg_pattern_decoder u_dec (
        .seg_n   (lat_pat_q[6:0]),
        .code    (dec_code),
        .invalid (dec_invalid)
    );

    assign an_low    = ~an_sync_q;
    assign an_single = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign same_sel  = (an_idx == lat_idx_q) && (pat_sync_q == lat_pat_q);

    always_comb begin
        an_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (an_low[i]) an_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d       = state_q;
        lat_idx_d     = lat_idx_q;
        lat_pat_d     = lat_pat_q;
        cnt_d         = cnt_q;
        to_cnt_d      = to_cnt_q;
        shadow_d      = shadow_q;
        digits_d      = digits_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        bad_d         = 1'b0;
        stale_d       = stale_q;
        capture       = 1'b0;
`ifdef SEVEN_SEG_READBACK_DP_EN
        shadow_dp_d   = shadow_dp_q;
        dp_d          = dp_q;
`endif

        case (state_q)
            IDLE: begin
                if (an_single) begin
                    state_d   = SETTLE;
                    lat_idx_d = an_idx;
                    lat_pat_d = pat_sync_q;
                    cnt_d     = '0;
                end
            end
            SETTLE: begin
                if (!an_single) begin
                    state_d = IDLE;
                end else if (!same_sel) begin
                    lat_idx_d = an_idx;
                    lat_pat_d = pat_sync_q;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = CAPTURED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURED: begin
                if (!an_single) begin
                    state_d = IDLE;
                end else if (!same_sel) begin
                    state_d   = SETTLE;
                    lat_idx_d = an_idx;
                    lat_pat_d = pat_sync_q;
                    cnt_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            shadow_d[4*lat_idx_q +: 4] = dec_code;
            seen_d[lat_idx_q]          = 1'b1;
            bad_d                      = dec_invalid;
`ifdef SEVEN_SEG_READBACK_DP_EN
            shadow_dp_d[lat_idx_q]     = ~lat_pat_q[7];
`endif
        end

        // A capture in the completing cycle lands in shadow first; publish next cycle.
        if ((&seen_q) && !capture) begin
            digits_d      = shadow_q;
            frame_valid_d = 1'b1;
            seen_d        = '0;
            stale_d       = 1'b0;
`ifdef SEVEN_SEG_READBACK_DP_EN
            dp_d          = shadow_dp_q;
`endif
        end

        if (capture) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            stale_d = 1'b1;
            seen_d  = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_meta_q     <= '1;
            an_sync_q     <= '1;
            pat_meta_q    <= '1;
            pat_sync_q    <= '1;
            state_q       <= IDLE;
            lat_idx_q     <= '0;
            lat_pat_q     <= '1;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            shadow_q      <= {NUM_DIGITS{CODE_BLANK}};
            digits_q      <= {NUM_DIGITS{CODE_BLANK}};
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            bad_q         <= 1'b0;
            stale_q       <= 1'b0;
`ifdef SEVEN_SEG_READBACK_DP_EN
            shadow_dp_q   <= '0;
            dp_q          <= '0;
`endif
        end else begin
            an_meta_q     <= an_n;
            an_sync_q     <= an_meta_q;
            pat_meta_q    <= pat_in;
            pat_sync_q    <= pat_meta_q;
            state_q       <= state_d;
            lat_idx_q     <= lat_idx_d;
            lat_pat_q     <= lat_pat_d;
            cnt_q         <= cnt_d;
            to_cnt_q      <= to_cnt_d;
            shadow_q      <= shadow_d;
            digits_q      <= digits_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            bad_q         <= bad_d;
            stale_q       <= stale_d;
`ifdef SEVEN_SEG_READBACK_DP_EN
            shadow_dp_q   <= shadow_dp_d;
            dp_q          <= dp_d;
`endif
        end
    end

    assign digits      = digits_q;
    assign frame_valid = frame_valid_q;
    assign bad_pattern = bad_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seven_seg_readback.sv
// Scoreboard bench for seven_seg_readback: directed scans push expected frames/bad-pattern
// events; a negedge monitor pops and compares whenever the DUT pulses an output.
module tb_seven_seg_readback;

    localparam int ND  = 4;
    localparam int STB = 8;
    localparam int TO  = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] an_n = '1;
    logic [6:0]    seg_n = 7'b1111111;
    logic [4*ND-1:0] digits;
    logic          frame_valid, bad_pattern, stale;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_frame_cyc = 0;

    logic [15:0] exp_frames[$];
    int          exp_bad[$];
    logic [15:0] exp_d;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9, written out independently.
    logic [6:0] pat [10];
    logic [6:0] bad_pat;

    seven_seg_readback #(
        .NUM_DIGITS     (ND),
        .STABLE_CYCLES  (STB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .digits      (digits),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .stale       (stale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_valid) begin
            last_frame_cyc = cyc;
            n_cmp++;
            if (exp_frames.size() == 0) begin
                n_bad++;
                $display("FAIL frame_unexpected digits=%h required=no_frame", digits);
            end else begin
                exp_d = exp_frames.pop_front();
                if (digits !== exp_d) begin
                    n_bad++;
                    $display("FAIL frame_digits got=%h required=%h", digits, exp_d);
                end
            end
        end
        if (bad_pattern) begin
            n_cmp++;
            if (exp_bad.size() == 0) begin
                n_bad++;
                $display("FAIL bad_pattern_unexpected got=1 required=0");
            end else begin
                void'(exp_bad.pop_front());
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic show(input int pos, input logic [6:0] p, input int ncyc);
        @(posedge clk);
        #1;
        an_n      = '1;
        an_n[pos] = 1'b0;
        seg_n     = p;
        repeat (ncyc - 1) @(posedge clk);
    endtask

    task automatic idle(input int ncyc);
        @(posedge clk);
        #1;
        an_n  = '1;
        seg_n = 7'b1111111;
        repeat (ncyc - 1) @(posedge clk);
    endtask

    task automatic scan(input int d0, input int d1, input int d2, input int d3);
        show(0, pat[d0], 20);
        show(1, pat[d1], 20);
        show(2, pat[d2], 20);
        show(3, pat[d3], 20);
        idle(5);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && (exp_frames.size() != 0 || exp_bad.size() != 0); i++)
            @(posedge clk);
        check(nm, exp_frames.size() + exp_bad.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pat[0] = 7'b1000000; pat[1] = 7'b1111001; pat[2] = 7'b0100100;
        pat[3] = 7'b0110000; pat[4] = 7'b0011001; pat[5] = 7'b0010010;
        pat[6] = 7'b0000010; pat[7] = 7'b1111000; pat[8] = 7'b0000000;
        pat[9] = 7'b0010000;
        bad_pat = 7'b0110110;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_digits", digits, 32'hEEEE);
        check("reset_frame_valid", frame_valid, 0);
        check("reset_bad_pattern", bad_pattern, 0);
        check("reset_stale", stale, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);

        // 1: plain scan 1,2,3,4
        exp_frames.push_back(16'h4321);
        scan(1, 2, 3, 4);
        drain("t1_drain");

        // 2: invalid pattern held on position 2
        exp_bad.push_back(1);
        exp_frames.push_back(16'h7F65);
        show(0, pat[5], 20);
        show(1, pat[6], 20);
        show(2, bad_pat, 40);
        show(3, pat[7], 20);
        idle(5);
        drain("t2_drain");

        // 3: 5-cycle glitch (an invalid pattern) opens position 1's slot
        exp_frames.push_back(16'h2089);
        show(0, pat[9], 20);
        show(1, bad_pat, 5);
        show(1, pat[8], 15);
        show(2, pat[0], 20);
        show(3, pat[2], 20);
        idle(5);
        drain("t3_drain");

        // 4: two anodes low is never a capture
        @(posedge clk);
        #1;
        an_n  = 4'b1100;
        seg_n = bad_pat;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("t4_state_idle", dut.state_q, seven_seg_pkg::IDLE);
        check("t4_digits_kept", digits, 32'h2089);
        idle(5);

        // 5: stale after TIMEOUT_CYCLES with no capture, cleared by a new frame
        for (int k = 0; k < 1000 && !stale; k++) @(negedge clk);
        check("t5_stale_set", stale, 1);
        check("t5_stale_latency", cyc - last_frame_cyc, TO - 1);
        check("t5_digits_kept", digits, 32'h2089);
        exp_frames.push_back(16'h5141);
        scan(1, 4, 1, 5);
        drain("t5_drain");
        @(negedge clk);
        check("t5_stale_cleared", stale, 0);

        // 6: reset while position 2 is still settling
        show(0, pat[2], 20);
        show(1, pat[7], 20);
        show(2, pat[9], 5);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_digits", digits, 32'hEEEE);
        check("t6_rst_frame_valid", frame_valid, 0);
        check("t6_rst_stale", stale, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        show(2, pat[9], 20);
        show(3, pat[6], 20);
        idle(30);
        check("t6_no_partial_frame", last_frame_cyc < 32'(cyc - 60), 1);
        exp_frames.push_back(16'h6972);
        scan(2, 7, 9, 6);
        drain("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
